// File: rtl/axi_line_bridge.sv
// Cache-line to AXI3 bridge: round-robin arbitration over N_PORTS line requesters,
// one INCR burst per request, a single transaction in flight.
//
// state  | meaning
// S_IDLE | waiting for a request; grant and latch on any req_valid
// S_AR   | read address valid, waiting for arready
// S_R    | collecting read beats into the line buffer until rlast
// S_AW   | write address valid, waiting for awready
// S_W    | streaming line words, wlast on the final word
// S_B    | waiting for the write response
// S_RESP | completion presented to the granted port until resp_ready
module axi_line_bridge #(
  parameter int N_PORTS    = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_PORTS-1:0]             req_valid,
  output logic [N_PORTS-1:0]             req_ready,
  input  logic [N_PORTS*32-1:0]          req_addr,
  input  logic [N_PORTS-1:0]             req_write,
  input  logic [N_PORTS*32*LINE_WORDS-1:0] req_data,
  output logic [N_PORTS-1:0]             resp_valid,
  input  logic [N_PORTS-1:0]             resp_ready,
  output logic [32*LINE_WORDS-1:0]       resp_data,
  output logic                           resp_err,
  output logic                           arvalid,
  output logic [3:0]                     arid,
  output logic [31:0]                    araddr,
  output logic [3:0]                     arlen,
  output logic [2:0]                     arsize,
  output logic [1:0]                     arburst,
  output logic [1:0]                     arlock,
  output logic [3:0]                     arcache,
  output logic [2:0]                     arprot,
  input  logic                           arready,
  output logic                           rready,
  input  logic                           rvalid,
  input  logic [3:0]                     rid,
  input  logic [31:0]                    rdata,
  input  logic [1:0]                     rresp,
  input  logic                           rlast,
  output logic                           awvalid,
  output logic [3:0]                     awid,
  output logic [31:0]                    awaddr,
  output logic [3:0]                     awlen,
  output logic [2:0]                     awsize,
  output logic [1:0]                     awburst,
  output logic [1:0]                     awlock,
  output logic [3:0]                     awcache,
  output logic [2:0]                     awprot,
  input  logic                           awready,
  output logic                           wvalid,
  output logic [3:0]                     wid,
  output logic [31:0]                    wdata,
  output logic [3:0]                     wstrb,
  output logic                           wlast,
  input  logic                           wready,
  output logic                           bready,
  input  logic                           bvalid,
  input  logic [3:0]                     bid,
  input  logic [1:0]                     bresp
);
  localparam int LW = 32 * LINE_WORDS;
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int OB = $clog2(4 * LINE_WORDS);
  localparam logic [31:0] ADDR_MASK = ~((32'd1 << OB) - 32'd1);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RESP} state_t;

  state_t            state;
  logic [PW-1:0]     port_q;
  logic [PW-1:0]     last_grant;
  logic [31:0]       addr_q;
  logic [LW-1:0]     line_q;
  logic [CW-1:0]     cnt_q;
  logic              full_q;
  logic              err_q;
  logic [PW-1:0]     grant;
  logic              any_req;
  int                idx;

  // IDs are not checked: only one transaction is ever outstanding.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  // Scan from farthest to nearest so the port right after last_grant wins.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = N_PORTS; i >= 1; i--) begin
      idx = (int'(last_grant) + i) % N_PORTS;
      if (req_valid[PW'(idx)]) begin
        grant   = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign req_ready = (state == S_IDLE && any_req && !rst) ? (N_PORTS'(1) << grant) : '0;

  assign araddr  = addr_q;
  assign arid    = 4'(port_q);
  assign arlen   = 4'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awaddr  = addr_q;
  assign awid    = 4'(port_q);
  assign awlen   = 4'(LINE_WORDS - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;
  assign wid     = 4'(port_q);
  assign wdata   = line_q[32*int'(cnt_q) +: 32];
  assign wstrb   = 4'hF;
  assign wlast   = (cnt_q == LAST);
  assign resp_data = line_q;
  assign resp_err  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= PW'(N_PORTS - 1);
      port_q     <= '0;
      addr_q     <= '0;
      line_q     <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      arvalid    <= 1'b0;
      awvalid    <= 1'b0;
      rready     <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          port_q     <= grant;
          last_grant <= grant;
          addr_q     <= req_addr[32*int'(grant) +: 32] & ADDR_MASK;
          cnt_q      <= '0;
          full_q     <= 1'b0;
          err_q      <= 1'b0;
          if (req_write[grant]) begin
            line_q  <= req_data[LW*int'(grant) +: LW];
            awvalid <= 1'b1;
            state   <= S_AW;
          end else begin
            arvalid <= 1'b1;
            state   <= S_AR;
          end
        end
        S_AR: if (arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= S_R;
        end
        S_R: if (rvalid) begin
          // Beats beyond the line length are dropped once the last slot is filled.
          if (!full_q) begin
            line_q[32*int'(cnt_q) +: 32] <= rdata;
            if (cnt_q == LAST) full_q <= 1'b1;
            else cnt_q <= cnt_q + 1'b1;
          end
          if (rresp != 2'b00) err_q <= 1'b1;
          if (rlast) begin
            rready     <= 1'b0;
            resp_valid <= N_PORTS'(1) << port_q;
            state      <= S_RESP;
          end
        end
        S_AW: if (awready) begin
          awvalid <= 1'b0;
          wvalid  <= 1'b1;
          state   <= S_W;
        end
        S_W: if (wready) begin
          if (cnt_q == LAST) begin
            wvalid <= 1'b0;
            bready <= 1'b1;
            cnt_q  <= '0;
            state  <= S_B;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_B: if (bvalid) begin
          bready <= 1'b0;
          if (bresp != 2'b00) err_q <= 1'b1;
          resp_valid <= N_PORTS'(1) << port_q;
          state      <= S_RESP;
        end
        S_RESP: if (resp_ready[port_q]) begin
          resp_valid <= '0;
          err_q      <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_line_bridge.sv
// Self-checking bench for axi_line_bridge: directed scenarios then randomized
// traffic, with the AXI slave and requesters played from one initial block.
module tb_axi_line_bridge;
  localparam int NP  = 2;
  localparam int LWD = 4;
  localparam int LW  = 32 * LWD;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    req_valid, req_ready, req_write, resp_valid, resp_ready;
  logic [NP*32-1:0] req_addr;
  logic [NP*LW-1:0] req_data;
  logic [LW-1:0]    resp_data;
  logic             resp_err;
  logic arvalid, arready, rready, rvalid, rlast, awvalid, awready;
  logic wvalid, wready, wlast, bready, bvalid;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, rid, wid, wstrb, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;

  int tests = 0, fails = 0, cyc = 0;
  int model_last = NP - 1;
  int keep = 0;
  int fixed_wait = -1;
  bit fixed_data = 1'b0;

  axi_line_bridge #(.N_PORTS(NP), .LINE_WORDS(LWD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .arvalid(arvalid), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot), .arready(arready),
    .rready(rready), .rvalid(rvalid), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
    .bready(bready), .bvalid(bvalid), .bid(bid), .bresp(bresp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {arvalid, awvalid, rready, wvalid, bready, req_ready, resp_valid, resp_err}, '0);
    chk({tag, "_data"}, resp_data, '0);
  endtask

  // Round-robin rule for two ports: the port after the last winner has priority.
  function automatic int model_grant(input logic [NP-1:0] v);
    int pref;
    pref = (model_last == 0) ? 1 : 0;
    if (v[pref]) return pref;
    return 1 - pref;
  endfunction

  function automatic int pick(input int m);
    if (fixed_wait >= 0) return fixed_wait;
    if (m == 0) return 0;
    return int'($urandom_range(m, 0));
  endfunction

  task automatic new_req(input int p);
    req_valid[p] = 1'b1;
    req_write[p] = 1'($urandom_range(1, 0));
    req_addr[p*32 +: 32] = $urandom;
    for (int i = 0; i < LWD; i++) req_data[p*LW + i*32 +: 32] = $urandom;
  endtask

  task automatic next_req(input int p);
    if (keep == 1 || (keep == 2 && $urandom_range(1, 0) == 1)) new_req(p);
    else req_valid[p] = 1'b0;
  endtask

  task automatic txn(input int wmax, input int err_beat, input bit berr, input int hold,
                     input bit abort, input int exp_lat);
    int t, d, gp, c0;
    bit wr, e;
    logic [31:0] a, w;
    logic [LW-1:0] line, wline;
    logic [NP-1:0] oh;
    logic [41:0] exp_w;
    e = 1'b0;
    line = '0;
    #1;
    t = 0;
    while (req_ready == '0 && t < 40) begin @(negedge clk); #1; t++; end
    gp = model_grant(req_valid);
    oh = NP'(1) << gp;
    chk("req_ready", req_ready, oh);
    if (req_ready == '0) return;
    wr    = req_write[gp];
    a     = req_addr[gp*32 +: 32] & 32'hFFFF_FFF0;
    wline = req_data[gp*LW +: LW];
    c0    = cyc;
    model_last = gp;
    @(negedge clk);
    next_req(gp);
    if (!wr) begin
      t = 0;
      while (!arvalid && t < 20) begin @(negedge clk); t++; end
      chk("ar_fields", {arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot},
          {1'b1, 4'(gp), a, 4'd3, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
      d = pick(wmax);
      repeat (d) begin @(negedge clk); chk("ar_hold", {arvalid, araddr}, {1'b1, a}); end
      arready = 1'b1; @(negedge clk); arready = 1'b0;
      for (int b = 0; b < LWD; b++) begin
        d = pick(wmax);
        repeat (d) @(negedge clk);
        chk("rready", rready, 1'b1);
        w = fixed_data ? 32'(32'hA0 + b) : $urandom;
        line[b*32 +: 32] = w;
        rvalid = 1'b1; rdata = w; rid = 4'(gp);
        rlast  = (b == LWD - 1);
        rresp  = (b == err_beat) ? 2'b10 : 2'b00;
        if (b == err_beat) e = 1'b1;
        if (abort && b == 2) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; req_valid = '0;
          model_last = NP - 1;
          #1;
          chk_reset("abort_reset");
          return;
        end
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end
    end else begin
      t = 0;
      while (!awvalid && t < 20) begin @(negedge clk); t++; end
      chk("aw_fields", {awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot},
          {1'b1, 4'(gp), a, 4'd3, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0});
      d = pick(wmax);
      repeat (d) begin @(negedge clk); chk("aw_hold", {awvalid, awaddr}, {1'b1, a}); end
      awready = 1'b1; @(negedge clk); awready = 1'b0;
      for (int b = 0; b < LWD; b++) begin
        exp_w = {1'b1, (b == LWD - 1), 4'hF, 4'(gp), wline[b*32 +: 32]};
        chk("w_beat", {wvalid, wlast, wstrb, wid, wdata}, exp_w);
        d = pick(wmax);
        repeat (d) begin @(negedge clk); chk("w_hold", {wvalid, wlast, wstrb, wid, wdata}, exp_w); end
        wready = 1'b1; @(negedge clk); wready = 1'b0;
      end
      chk("bready", bready, 1'b1);
      d = pick(wmax);
      repeat (d) begin @(negedge clk); chk("b_wait_no_resp", resp_valid, '0); end
      bvalid = 1'b1; bid = 4'(gp); bresp = berr ? 2'b10 : 2'b00; e = berr;
      @(negedge clk);
      bvalid = 1'b0; bresp = 2'b00;
    end
    chk("resp_valid", resp_valid, oh);
    chk("resp_err", resp_err, e);
    if (!wr) chk("resp_data", resp_data, line);
    if (exp_lat >= 0) chk("latency", cyc - c0, exp_lat);
    repeat (hold) begin
      @(negedge clk);
      chk("resp_hold", {req_ready, resp_valid, resp_err}, {{NP{1'b0}}, oh, e});
      if (!wr) chk("resp_hold_data", resp_data, line);
    end
    resp_ready[gp] = 1'b1;
    @(negedge clk);
    resp_ready = '0;
    chk("resp_drop", resp_valid, '0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_data = '0; resp_ready = '0;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset("reset");

    // Zero-wait read of a misaligned address, fixed beat data A0..A3.
    keep = 0; fixed_data = 1'b1; fixed_wait = 0;
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[31:0] = 32'h1FC0_0004;
    txn(0, -1, 1'b0, 0, 1'b0, 6);
    fixed_data = 1'b0;

    // Zero-wait write latency.
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[31:0] = 32'h0000_2040;
    req_data[LW-1:0] = {32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001, 32'hDEAD_0000};
    txn(0, -1, 1'b0, 0, 1'b0, 7);

    // Port 1 write with wready toggling.
    fixed_wait = 1;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[63:32] = 32'h0000_1010;
    req_data[2*LW-1:LW] = {32'h44, 32'h33, 32'h22, 32'h11};
    txn(0, -1, 1'b0, 0, 1'b0, -1);
    fixed_wait = -1;

    // Both ports continuously requesting: grants must alternate.
    keep = 1;
    new_req(0); new_req(1);
    for (int k = 0; k < 4; k++) txn(2, -1, 1'b0, 0, 1'b0, -1);
    keep = 0; req_valid = '0;

    // Read error on beat 2, then a clean transaction.
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[31:0] = $urandom;
    txn(1, 2, 1'b0, 0, 1'b0, -1);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[63:32] = $urandom;
    txn(1, -1, 1'b0, 0, 1'b0, -1);

    // Write response error.
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[63:32] = $urandom;
    txn(1, -1, 1'b1, 0, 1'b0, -1);

    // Completion held for 5 cycles while the other port waits.
    new_req(0); new_req(1); req_write[0] = 1'b0; req_write[1] = 1'b0;
    txn(1, -1, 1'b0, 5, 1'b0, -1);
    txn(1, -1, 1'b0, 0, 1'b0, -1);

    // Reset during read beat 2, then a fresh read where port 0 must win.
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[63:32] = $urandom;
    txn(0, -1, 1'b0, 0, 1'b1, -1);
    new_req(0); new_req(1); req_write[0] = 1'b0;
    keep = 0;
    txn(0, -1, 1'b0, 0, 1'b0, 6);
    txn(1, -1, 1'b0, 0, 1'b0, -1);

    // Randomized traffic.
    keep = 2;
    for (int k = 0; k < 30; k++) begin
      for (int p = 0; p < NP; p++)
        if (!req_valid[p] && $urandom_range(1, 0) == 1) new_req(p);
      if (req_valid == '0) new_req(0);
      txn(3, ($urandom_range(5, 0) == 0) ? int'($urandom_range(3, 0)) : -1,
          ($urandom_range(5, 0) == 0), int'($urandom_range(3, 0)), 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
